// File: rtl/shift_pkg.sv
// Shared definitions for the serial word receiver.
//   DEFAULT_WIDTH : default word length in bits
//   state_t       : receiver FSM states (IDLE = waiting for a start bit,
//                   RECV = a frame is partially received)
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/rx_shift_core.sv
// Shift register and bit counter for the serial word receiver.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (clears shreg and count)
//   clear  in  discard the current contents; combined with shift it starts a
//              new frame with sin as the first bit (count = 1)
//   shift  in  shift sin into the LSB and increment the count
//   sin    in  serial data bit
//   shreg  out shift register contents
//   count  out number of bits currently held
module rx_shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] shreg,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            if (shift) begin
                // Restart: the first bit enters at the LSB and reaches the
                // MSB position once the remaining WIDTH-1 bits are shifted in.
                shreg <= {{(WIDTH-1){1'b0}}, sin};
                count <= CNT_W'(1);
            end else begin
                shreg <= '0;
                count <= '0;
            end
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], sin};
            // Saturate so the count can never wrap.
            if (count < CNT_W'(WIDTH)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver, MSB first, with a one-word output
// holding register, valid/ready handshake and sticky error flags.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   sin        in  serial data bit, sampled when sin_valid = 1
//   sin_valid  in  bit strobe
//   start      in  marks the current (valid) bit as the MSB of a new word
//   out_ready  in  downstream accepts out_data
//   clr_err    in  clears overrun and frame_err
//   out_data   out received parallel word
//   out_valid  out out_data holds an unconsumed word
//   busy       out a frame is partially received
//   overrun    out sticky: a completed word was dropped (output still full)
//   frame_err  out sticky: start arrived in the middle of a frame
module serial_word_receiver
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic               clear;
    logic               shift;
    logic               complete;
    logic               fe_set;
    logic               ov_set;
    logic               handshake;
    logic               load_word;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   word;
    logic               shreg_msb_unused;

    rx_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .shift (shift),
        .sin   (sin),
        .shreg (shreg),
        .count (count)
    );

    // The completing bit is merged combinationally so the word is visible on
    // the same edge that samples the last bit. The shift register's top bit is
    // always zero at that point (only WIDTH-1 bits have been shifted in).
    assign word             = {shreg[WIDTH-2:0], sin};
    assign shreg_msb_unused = shreg[WIDTH-1];

    assign busy      = (state == RECV);
    assign handshake = out_valid && out_ready;
    assign load_word = complete && (!out_valid || out_ready);
    assign ov_set    = complete && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        shift      = 1'b0;
        complete   = 1'b0;
        fe_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sin_valid && start) begin
                    clear      = 1'b1;
                    shift      = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (sin_valid) begin
                    if (start) begin
                        // Abandon the partial word and restart on this bit.
                        clear  = 1'b1;
                        shift  = 1'b1;
                        fe_set = 1'b1;
                    end else if (count == CNT_W'(WIDTH - 1)) begin
                        clear      = 1'b1;
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load_word) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            // A set event in the same cycle as clr_err wins.
            overrun   <= ov_set | (overrun & ~clr_err);
            frame_err <= fe_set | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .start     (start),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bits of the frame in progress, the held output word,
    // the sticky flags, and the words the DUT is expected to deliver.
    bit           frame_bits[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] m_data  = '0;
    bit           m_valid = 1'b0;
    bit           m_ov    = 1'b0;
    bit           m_fe    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        bit           done;
        bit           fe_ev;
        logic [W-1:0] w;
        done  = 1'b0;
        fe_ev = 1'b0;
        w     = '0;
        if (rst) begin
            frame_bits.delete();
            sb.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ov    = 1'b0;
            m_fe    = 1'b0;
        end else begin
            if (sin_valid) begin
                if (start) begin
                    if (frame_bits.size() > 0) fe_ev = 1'b1;
                    frame_bits.delete();
                    frame_bits.push_back(sin);
                end else if (frame_bits.size() > 0) begin
                    frame_bits.push_back(sin);
                    if (frame_bits.size() == W) begin
                        foreach (frame_bits[i]) w = {w[W-2:0], frame_bits[i]};
                        frame_bits.delete();
                        done = 1'b1;
                    end
                end
            end
            if (done && m_valid && !out_ready) begin
                m_ov = 1'b1;
            end else if (clr_err) begin
                m_ov = 1'b0;
            end
            if (fe_ev) begin
                m_fe = 1'b1;
            end else if (clr_err) begin
                m_fe = 1'b0;
            end
            if (done && (!m_valid || out_ready)) begin
                m_data  = w;
                m_valid = 1'b1;
                sb.push_back(w);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit v, input bit b, input bit st, input bit rdy, input bit clr, input bit r);
        @(posedge clk);
        model_step();
        #1;
        sin_valid = v;
        sin       = b;
        start     = st;
        out_ready = rdy;
        clr_err   = clr;
        rst       = r;
    endtask

    task automatic frame(input logic [W-1:0] w, input int gap, input bit rdy);
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, w[W-1-i], (i == 0), rdy, 1'b0, 1'b0);
            if (i < W - 1) begin
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: state and flags every cycle, delivered words on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(frame_bits.size() > 0));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data_held", 32'(out_data), 32'(m_data));
            chk("overrun", 32'(overrun), 32'(m_ov));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_word: got 0x%0h, expected no word at %0t", out_data, $time);
                end else begin
                    chk("sb_word", 32'(out_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        bit v, b, st, rdy, clr, r;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back bits, immediately consumed.
        frame(4'b1011, 0, 1'b1);
        idle(3, 1'b1);

        // Bits separated by idle cycles.
        frame(4'b1100, 3, 1'b1);
        idle(3, 1'b1);

        // Output held while the second word is dropped; then clear and drain.
        frame(4'b0110, 0, 1'b0);
        frame(4'b1001, 0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Start in the middle of a frame.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(4'b0111, 0, 1'b1);
        idle(2, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Reset mid-frame, then a full frame.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        frame(4'b1010, 0, 1'b1);
        idle(2, 1'b1);

        // Completion in the same cycle as a handshake of the previous word.
        frame(4'b1111, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom_range(0, 9) < 6);
            b   = 1'($urandom);
            st  = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 199) == 0);
            cyc(v, b, st, rdy, clr, r);
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
